seq_div: RTL and testbench

Sequential restoring divider: an unsigned WIDTH-bit dividend is divided by a WIDTH-bit divisor, producing one quotient bit per clock. It performs the inverse of the team's combinational multiplier blocks and is intended for datapaths where area matters more than latency. A single start/done handshake launches the operation and returns the result. Results are held stable until the next accepted start.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 35 +++
 rtl/fa.sv | 13 +
 rtl/seq_div.sv | 101 ++++++++++
 tb/tb_seq_div.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The FSM state encoding and counter sizing live here so both ends of the datapath agree.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: trial-subtract the divisor from the shifted partial
// remainder and keep the difference only when it did not borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0]   dvs_inv;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] carry;

  // p - d is formed as p + ~d + 1; a final carry of 1 means no borrow.
  assign dvs_inv  = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
      fa u_fa (
        .a    (p_shift[gi]),
        .b    (dvs_inv[gi]),
        .cin  (carry[gi]),
        .s    (diff[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign q_bit  = carry[WIDTH+1];
  assign p_next = q_bit ? diff : p_shift;

endmodule

// File: rtl/fa.sv
// One-bit full adder cell, the building block of the ripple subtractor.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock with a start/done handshake.
// Results are held until the next accepted start or reset.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvs_reg;

  logic [2*WIDTH:0] pq_shift;
  logic [WIDTH:0]   p_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  // {P,Q} shifted as one register; the step fills the freed Q[0] with the quotient bit.
  assign pq_shift = {p_reg, q_reg} << 1;
  assign q_next   = pq_shift[WIDTH-1:0] | WIDTH'(q_bit);

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_shift (pq_shift[2*WIDTH:WIDTH]),
    .divisor (dvs_reg),
    .p_next  (p_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              p_reg     <= '0;
              q_reg     <= dividend;
              dvs_reg   <= divisor;
              cnt_reg   <= CW'(WIDTH);
              busy      <= 1'b1;
              state_reg <= RUN;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_reg   <= DONE;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          p_reg   <= p_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            quotient    <= q_next;
            remainder   <= p_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_reg   <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: an arithmetic reference model checked every cycle on
// an 8-bit instance, directed literal checks, and an exhaustive sweep of a 2-bit instance.
module tb_seq_div;

  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       start8, busy8, done8, dbz8;
  logic [7:0] dvd8, dvs8, q8, r8;
  logic       start2, busy2, done2, dbz2;
  logic [1:0] dvd2, dvs2, q2, r2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  seq_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  seq_div #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dividend(dvd2), .divisor(dvs2),
    .busy(busy2), .done(done2), .quotient(q2), .remainder(r2), .div_by_zero(dbz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: results come from / and %, timing from the cycle budget W.
  logic       m_busy, m_done, m_dbz;
  logic [7:0] m_q, m_r, p_q, p_r;
  int         m_left;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_q <= 0; m_r <= 0; m_dbz <= 0; m_left <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 0; m_done <= 1; m_q <= p_q; m_r <= p_r; m_dbz <= 0;
      end
    end else begin
      m_done <= 0;
      if (start8) begin
        if (dvs8 != 0) begin
          m_left <= W; m_busy <= 1; p_q <= dvd8 / dvs8; p_r <= dvd8 % dvs8;
        end else begin
          m_done <= 1; m_q <= 8'hFF; m_r <= dvd8; m_dbz <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy8, m_busy);
      check("cyc_done", done8, m_done);
      check("cyc_quot", q8, m_q);
      check("cyc_rem", r8, m_r);
      check("cyc_dbz", dbz8, m_dbz);
    end
  end

  // Issue one operation on the 8-bit DUT; lat = cycles from accept to done seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    start8 = 1; dvd8 = a; dvs8 = b;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      start8 = 0;
      lat++;
    end while (!done8 && lat < 40);
    if (!done8) check("done_timeout", 0, 1);
  endtask

  int lat, pulses, k, b1;
  logic [7:0] cq, cr;

  initial begin
    rst_n = 0; start8 = 0; dvd8 = 0; dvs8 = 0; start2 = 0; dvd2 = 0; dvs2 = 0;
    @(posedge clk);
    chk_en = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_quot", q8, 0);
    check("rst_rem", r8, 0);
    check("rst_dbz", dbz8, 0);
    rst_n = 1;
    @(negedge clk);

    run_op(100, 7, lat);
    $display("op 100/7: lat=%0d q=%0d r=%0d dbz=%0d", lat, q8, r8, dbz8);
    check("lat_100_7", lat, 9);
    check("q_100_7", q8, 14);
    check("r_100_7", r8, 2);
    check("dbz_100_7", dbz8, 0);

    run_op(255, 1, lat);
    $display("op 255/1: lat=%0d q=%0d r=%0d", lat, q8, r8);
    check("q_255_1", q8, 255);
    check("r_255_1", r8, 0);
    run_op(5, 9, lat);
    $display("op 5/9 back-to-back: lat=%0d q=%0d r=%0d", lat, q8, r8);
    check("lat_b2b", lat, 9);
    check("q_5_9", q8, 0);
    check("r_5_9", r8, 5);

    repeat (2) @(negedge clk);
    run_op(37, 0, lat);
    $display("op 37/0: lat=%0d q=%0d r=%0d dbz=%0d", lat, q8, r8, dbz8);
    check("lat_div0", lat, 1);
    check("q_div0", q8, 255);
    check("r_div0", r8, 37);
    check("dbz_div0", dbz8, 1);
    check("busy_div0", busy8, 0);

    // start pulsed mid-run must be ignored
    repeat (2) @(negedge clk);
    start8 = 1; dvd8 = 100; dvs8 = 7;
    @(posedge clk);
    @(negedge clk); start8 = 0;
    repeat (3) @(negedge clk);
    start8 = 1; dvd8 = 200; dvs8 = 3;
    @(negedge clk); start8 = 0;
    pulses = 0; cq = 0; cr = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) begin
        pulses++;
        cq = q8; cr = r8;
      end
    end
    $display("op 100/7 with ignored 200/3: pulses=%0d q=%0d r=%0d", pulses, cq, cr);
    check("ignored_pulses", pulses, 1);
    check("ignored_q", cq, 14);
    check("ignored_r", cr, 2);

    // reset mid-run discards the operation
    start8 = 1; dvd8 = 100; dvs8 = 7;
    @(posedge clk);
    @(negedge clk); start8 = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("mrst_busy", busy8, 0);
    check("mrst_done", done8, 0);
    check("mrst_quot", q8, 0);
    check("mrst_rem", r8, 0);
    check("mrst_dbz", dbz8, 0);
    rst_n = 1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    $display("reset mid-run: done pulses afterwards=%0d", pulses);
    check("mrst_no_done", pulses, 0);
    run_op(9, 4, lat);
    $display("op 9/4: lat=%0d q=%0d r=%0d", lat, q8, r8);
    check("q_9_4", q8, 2);
    check("r_9_4", r8, 1);

    // exhaustive 2-bit sweep, issued back to back
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        start2 = 1; dvd2 = 2'(a); dvs2 = 2'(b);
        @(posedge clk);
        k = 0; b1 = 0;
        do begin
          @(negedge clk);
          start2 = 0;
          k++;
          if (k == 1) b1 = int'(busy2);
        end while (!done2 && k < 10);
        $display("w2 op %0d/%0d: lat=%0d q=%0d r=%0d dbz=%0d", a, b, k, q2, r2, dbz2);
        check("w2_busy", b1, (b != 0) ? 1 : 0);
        if (b != 0) begin
          check("w2_lat", k, 3);
          check("w2_inv", 32'(q2) * b + 32'(r2), a);
          check("w2_rem_lt", (int'(r2) < b) ? 1 : 0, 1);
          check("w2_dbz", dbz2, 0);
        end else begin
          check("w2_lat0", k, 1);
          check("w2_q0", q2, 3);
          check("w2_r0", r2, a);
          check("w2_dbz0", dbz2, 1);
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
